// File: rtl/cb_desegment_crc_check_pkg.sv
// ============================================================================
//  Package   : LDPC_pkg
//  Purpose   : Shared constants and types for the LDPC receive/transmit chain.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package LDPC_pkg;

    localparam int                 CRC24_W     = 24;
    localparam logic [CRC24_W-1:0] CRC24A_POLY = 24'h864CFB;
    localparam int                 CNT_W       = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PASS  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } deseg_state_t;

endpackage

`default_nettype wire

// File: rtl/cb_desegment_crc_check_crc24a.sv
// ============================================================================
//  Module    : crc24a_word_update
//  Purpose   : Folds the first nbits of a word (MSB first) into a CRC24A value.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc24a_word_update
    import LDPC_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NB_W   = $clog2(DATA_W + 1)
) (
    input  logic [CRC24_W-1:0] crc_in,
    input  logic [DATA_W-1:0]  data,
    input  logic [NB_W-1:0]    nbits,
    output logic [CRC24_W-1:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits)) begin
                if (crc_out[CRC24_W-1] ^ data[DATA_W-1-i])
                    crc_out = {crc_out[CRC24_W-2:0], 1'b0} ^ CRC24A_POLY;
                else
                    crc_out = {crc_out[CRC24_W-2:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cb_desegment_crc_check.sv
// ============================================================================
//  Module    : cb_desegment_crc_check
//  Purpose   : Strips filler bits from a decoded code block and checks CRC24A.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module cb_desegment_crc_check
    import LDPC_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          params_valid,
    input  logic [12:0]                   mssg_size_in_bg,
    input  logic [13:0]                   tb_with_crc_size,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(DATA_W+1)-1:0]   out_nbits,
    output logic                          busy,
    output logic                          param_err,
    output logic                          crc_done,
    output logic                          crc_ok
);

    localparam int              NB_W       = $clog2(DATA_W + 1);
    localparam logic [NB_W-1:0] FULL_NBITS = NB_W'(DATA_W);

    deseg_state_t state, state_next;

    logic [12:0]        cb_size;
    logic [13:0]        tb_size;
    logic [CNT_W-1:0]   out_words, in_words, in_cnt;
    logic [CNT_W-1:0]   out_words_calc, in_words_calc;
    logic [NB_W-1:0]    tail_bits, tail_calc, word_nbits;
    logic [DATA_W-1:0]  word_mask, word_data, ones;
    logic [CRC24_W-1:0] crc, crc_next;
    logic               params_bad, accept, last_word, in_done;

    assign params_bad = (tb_with_crc_size < 14'd25) ||
                        (tb_with_crc_size > {1'b0, mssg_size_in_bg});

    always_comb begin
        out_words_calc = CNT_W'((int'(tb_size) + DATA_W - 1) / DATA_W);
        in_words_calc  = CNT_W'((int'(cb_size) + DATA_W - 1) / DATA_W);
        tail_calc      = NB_W'(int'(tb_size) - (int'(out_words_calc) - 1) * DATA_W);
    end

    // Single output register: a new word may enter only when the register frees up.
    assign in_ready = ((state == S_PASS) && (in_cnt < out_words) && (!out_valid || out_ready)) ||
                      ((state == S_DRAIN) && (in_cnt < in_words));
    assign accept    = in_valid && in_ready;
    assign last_word = ((in_cnt + CNT_W'(1)) == out_words);
    assign in_done   = (in_cnt == in_words) || (accept && ((in_cnt + CNT_W'(1)) == in_words));

    assign ones       = '1;
    assign word_nbits = last_word ? tail_bits : FULL_NBITS;
    assign word_mask  = last_word ? ~(ones >> tail_bits) : ones;
    assign word_data  = in_data & word_mask;

    crc24a_word_update #(
        .DATA_W (DATA_W),
        .NB_W   (NB_W)
    ) u_crc (
        .crc_in  (crc),
        .data    (word_data),
        .nbits   (word_nbits),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        crc_done   = (state == S_DONE);
        case (state)
            S_IDLE:  if (params_valid && !params_bad) state_next = S_LOAD;
            S_LOAD:  state_next = S_PASS;
            S_PASS: begin
                if (accept && last_word) begin
                    if (in_words > out_words) state_next = S_DRAIN;
                end else if ((in_cnt == out_words) && out_valid && out_ready) begin
                    state_next = S_DONE;
                end
            end
            S_DRAIN: if (in_done && (!out_valid || out_ready)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cb_size   <= '0;
            tb_size   <= '0;
            out_words <= '0;
            in_words  <= '0;
            tail_bits <= '0;
            in_cnt    <= '0;
            crc       <= '0;
            out_data  <= '0;
            out_nbits <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            param_err <= 1'b0;
            crc_ok    <= 1'b0;
        end else begin
            param_err <= 1'b0;
            if (state == S_IDLE && params_valid) begin
                cb_size   <= mssg_size_in_bg;
                tb_size   <= tb_with_crc_size;
                param_err <= params_bad;
                if (!params_bad) begin
                    crc    <= '0;
                    crc_ok <= 1'b0;
                    in_cnt <= '0;
                end
            end
            if (state == S_LOAD) begin
                out_words <= out_words_calc;
                in_words  <= in_words_calc;
                tail_bits <= tail_calc;
            end
            if (accept) in_cnt <= in_cnt + CNT_W'(1);
            if (accept && state == S_PASS) begin
                out_data  <= word_data;
                out_nbits <= word_nbits;
                out_last  <= last_word;
                out_valid <= 1'b1;
                crc       <= crc_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // Every forwarded bit has been folded in by the time DONE is entered.
            if (state != S_DONE && state_next == S_DONE) crc_ok <= (crc == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cb_desegment_crc_check.sv
// ============================================================================
//  Module    : tb_cb_desegment_crc_check
//  Purpose   : Scoreboard bench for cb_desegment_crc_check with a bit-level model.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cb_desegment_crc_check;

    localparam int DATA_W = 8;
    localparam int NB_W   = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              params_valid = 1'b0;
    logic [12:0]       mssg_size_in_bg = '0;
    logic [13:0]       tb_with_crc_size = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [NB_W-1:0]   out_nbits;
    logic              busy, param_err, crc_done, crc_ok;

    cb_desegment_crc_check #(.DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .params_valid     (params_valid),
        .mssg_size_in_bg  (mssg_size_in_bg),
        .tb_with_crc_size (tb_with_crc_size),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .out_nbits        (out_nbits),
        .busy             (busy),
        .param_err        (param_err),
        .crc_done         (crc_done),
        .crc_ok           (crc_ok)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                nbits;
        bit                last;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_ok_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, done_edge = 0, last_in_edge = 0, last_out_edge = 0;
    bit bp_mode = 1'b0, ignore_out = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk); #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Remainder of msg(x)*x^24 divided by the CRC24A generator, by long division.
    function automatic logic [23:0] ref_crc(input bit msg[$]);
        bit          r[$];
        logic [24:0] gen = 25'h1864CFB;
        logic [23:0] rem;
        r = msg;
        for (int k = 0; k < 24; k++) r.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (r[i]) for (int j = 0; j < 25; j++) r[i+j] ^= gen[24-j];
        for (int k = 0; k < 24; k++) rem[23-k] = r[msg.size()+k];
        return rem;
    endfunction

    // Output monitor / scoreboard.
    initial begin
        beat_t                 b;
        bit                    hold = 1'b0;
        logic [DATA_W+NB_W:0]  held = '0;
        forever begin
            @(negedge clk);
            if (reset || ignore_out) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_stable", {out_data, out_nbits, out_last}, held);
                end
                if (out_valid && out_ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        check("beat_data", out_data, b.data);
                        check("beat_nbits", out_nbits, b.nbits);
                        check("beat_last", out_last, b.last);
                    end
                    if (out_last) last_out_edge = cyc + 1;
                end
                hold = out_valid && !out_ready;
                held = {out_data, out_nbits, out_last};
                if (crc_done) begin
                    done_edge = cyc;
                    done_cnt++;
                    check("crc_result_expected", exp_ok_q.size() > 0, 1);
                    if (exp_ok_q.size() > 0) check("crc_ok", crc_ok, exp_ok_q.pop_front());
                end
            end
        end
    end

    task automatic run_case(input int ncb, input int ntb, input bit flip, input bit bp, input bit gaps);
        bit                bits[$];
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] d;
        logic [23:0]       c;
        beat_t             b;
        int                nin, nout, k, idx, guard, done0;
        for (int i = 0; i < ntb - 24; i++) bits.push_back(1'($urandom_range(0, 1)));
        c = ref_crc(bits);
        for (int i = 23; i >= 0; i--) bits.push_back(c[i]);
        if (flip) begin
            k = $urandom_range(0, ntb - 25);
            bits[k] = ~bits[k];
        end
        while (bits.size() < ncb) bits.push_back(1'($urandom_range(0, 1)));
        nin  = (ncb + DATA_W - 1) / DATA_W;
        nout = (ntb + DATA_W - 1) / DATA_W;
        for (int w = 0; w < nin; w++) begin
            for (int i = 0; i < DATA_W; i++) begin
                idx = w * DATA_W + i;
                d[DATA_W-1-i] = (idx < ncb) ? bits[idx] : 1'($urandom_range(0, 1));
            end
            words.push_back(d);
        end
        for (int w = 0; w < nout; w++) begin
            b.data = '0;
            for (int i = 0; i < DATA_W; i++) begin
                idx = w * DATA_W + i;
                if (idx < ntb) b.data[DATA_W-1-i] = bits[idx];
            end
            b.nbits = (ntb - w * DATA_W > DATA_W) ? DATA_W : ntb - w * DATA_W;
            b.last  = (w == nout - 1);
            exp_q.push_back(b);
        end
        exp_ok_q.push_back(!flip);
        bp_mode = bp;
        done0   = done_cnt;

        @(posedge clk); #1;
        params_valid     = 1'b1;
        mssg_size_in_bg  = 13'(ncb);
        tb_with_crc_size = 14'(ntb);
        @(posedge clk); #1;
        params_valid = 1'b0;

        k = 0;
        guard = 0;
        while (k < nin && guard < 20000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = words[k];
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (k == nin - 1) last_in_edge = cyc + 1;
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("in_words_consumed", k, nin);

        guard = 0;
        while (done_cnt == done0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("crc_done_count", done_cnt - done0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        if (!bp && !gaps)
            check("crc_done_timing", done_edge, (nin > nout) ? last_in_edge : last_out_edge);
        @(posedge clk); #1;
        check("crc_ok_held", crc_ok, !flip);
        check("idle_after_done", busy, 0);
    endtask

    task automatic param_error_case(input int ncb, input int ntb);
        @(posedge clk); #1;
        params_valid     = 1'b1;
        mssg_size_in_bg  = 13'(ncb);
        tb_with_crc_size = 14'(ntb);
        @(posedge clk); #1;
        params_valid = 1'b0;
        check("param_err_pulse", param_err, 1);
        check("param_err_busy", busy, 0);
        check("param_err_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("param_err_one_cycle", param_err, 0);
        check("param_err_still_idle", {busy, in_ready}, 0);
    endtask

    initial begin
        int ncb, ntb;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshake", {in_ready, out_valid, out_last}, 0);
        check("rst_status", {busy, param_err, crc_done, crc_ok}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_nbits", out_nbits, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_case(80, 80, 1'b0, 1'b0, 1'b0);
        run_case(176, 100, 1'b0, 1'b0, 1'b0);
        run_case(176, 100, 1'b1, 1'b0, 1'b0);
        run_case(240, 200, 1'b0, 1'b1, 1'b1);
        param_error_case(176, 200);
        param_error_case(176, 24);

        // Abort a transfer mid-PASS with reset, then run a clean one.
        ignore_out = 1'b1;
        bp_mode    = 1'b0;
        @(posedge clk); #1;
        params_valid     = 1'b1;
        mssg_size_in_bg  = 13'd240;
        tb_with_crc_size = 14'd200;
        @(posedge clk); #1;
        params_valid = 1'b0;
        in_valid     = 1'b1;
        repeat (6) begin
            in_data = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        check("mid_pass_busy", busy, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_handshake", {in_ready, out_valid, out_last}, 0);
        check("midrst_status", {busy, param_err, crc_done, crc_ok}, 0);
        check("midrst_out", {out_data, out_nbits}, 0);
        reset = 1'b0;
        exp_q.delete();
        exp_ok_q.delete();
        ignore_out = 1'b0;
        run_case(240, 200, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            ncb = $urandom_range(25, 600);
            ntb = $urandom_range(25, ncb);
            run_case(ncb, ntb, r[0], r[1], r[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
